// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported system RAM between instruction fetch and data access.
// Data wins by default; a starvation counter forces a pending fetch through after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t    state;
    logic [3:0] starve;
    ramstate_t ram_st;
    logic      d_req;
    logic      ram_access;
    logic      ram_error;
    logic      ihit;
    logic      dhit;
    logic      grant_req;
    logic      grant_done;

    assign ram_st     = ramstate_t'(ramstate);
    assign d_req      = dREN | dWEN;
    assign ram_access = (ram_st == ACCESS);
    assign ram_error  = (ram_st == ERROR);

    // A hit is suppressed while RST is asserted so a reset cycle never completes an access.
    assign ihit = (state == IGRANT) && ram_access && !RST;
    assign dhit = (state == DGRANT) && ram_access && !RST;

    assign iwait = ~ihit;
    assign dwait = ~dhit;
    assign iload = ihit ? ramload : 32'h0;
    assign dload = dhit ? ramload : 32'h0;

    assign grant_req  = (state == DGRANT) ? d_req : iREN;
    assign grant_done = ram_access || ram_error || !grant_req;

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            starve    <= 4'd0;
            err_count <= 8'd0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= 32'h0;
            ramstore  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !(iREN && starve == STARVE_LIM)) begin
                        state    <= DGRANT;
                        ramWEN   <= dWEN;
                        ramREN   <= ~dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        if (iREN)
                            starve <= (starve == STARVE_LIM) ? STARVE_LIM : starve + 4'd1;
                        else
                            starve <= 4'd0;
                    end else if (iREN) begin
                        state    <= IGRANT;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        ramaddr  <= iaddr;
                        ramstore <= 32'h0;
                        starve   <= 4'd0;
                    end else begin
                        starve <= 4'd0;
                    end
                end

                DGRANT, IGRANT: begin
                    if (ram_error && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                    // Completion, error and withdrawal all return through one IDLE bubble.
                    if (grant_done) begin
                        state    <= IDLE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= 32'h0;
                        ramstore <= 32'h0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    ramREN   <= 1'b0;
                    ramWEN   <= 1'b0;
                    ramaddr  <= 32'h0;
                    ramstore <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: priority, starvation, write, error retry, withdrawal, reset.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .ramstate  (ramstate),
        .ramload   (ramload),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .err_count (err_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramstate = FREE; ramload = 32'h0;
        repeat (3) tick();
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL reset_iwait: got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL reset_dwait: got %b want 1", dwait); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_enables: got %b want 00", {ramREN, ramWEN}); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram_bus: got addr %h store %h want 0", ramaddr, ramstore); end
        checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL reset_loads: got %h %h want 0", iload, dload); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (dut.starve !== 4'd0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starve); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch;
        iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h55;
        #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL idle_access_ignored: iwait %b want 1", iwait); end
        tick();
        ramstate = BUSY;
        #1;
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_grant1: ren %b wen %b addr %h want 1 0 40", ramREN, ramWEN, ramaddr); end
        checks++; if (iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL fetch_busy_wait: iwait %b iload %h want 1 0", iwait, iload); end
        tick();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_grant2: ren %b addr %h want 1 40", ramREN, ramaddr); end
        tick();
        ramstate = ACCESS; ramload = 32'h2108000A;
        #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL fetch_grant3: ren %b want 1", ramREN); end
        checks++; if (iwait !== 1'b0 || iload !== 32'h2108000A) begin errors++; $display("FAIL fetch_hit: iwait %b iload %h want 0 2108000a", iwait, iload); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL fetch_hit_dwait: dwait %b want 1", dwait); end
        tick();
        iREN = 1'b0; ramstate = FREE;
        #1;
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL fetch_bubble: ren %b addr %h iwait %b iload %h want 0 0 1 0", ramREN, ramaddr, iwait, iload); end
        tick();
    endtask

    task automatic test_data_priority;
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80;
        tick();
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80) begin errors++; $display("FAIL prio_dgrant: ren %b wen %b addr %h want 1 0 80", ramREN, ramWEN, ramaddr); end
        checks++; if (dut.starve !== 4'd1) begin errors++; $display("FAIL prio_starve_inc: got %0d want 1", dut.starve); end
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'h0BADF00D) begin errors++; $display("FAIL prio_dhit: dwait %b dload %h want 0 0badf00d", dwait, dload); end
        checks++; if (iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL prio_iwait_held: iwait %b iload %h want 1 0", iwait, iload); end
        tick();
        dREN = 1'b0; ramstate = FREE;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL prio_bubble: ren %b dwait %b want 0 1", ramREN, dwait); end
        tick();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || dut.starve !== 4'd0) begin errors++; $display("FAIL prio_igrant: ren %b addr %h starve %0d want 1 44 0", ramREN, ramaddr, dut.starve); end
        ramstate = ACCESS; ramload = 32'h12345678;
        #1;
        checks++; if (iwait !== 1'b0 || iload !== 32'h12345678) begin errors++; $display("FAIL prio_ihit: iwait %b iload %h want 0 12345678", iwait, iload); end
        tick();
        iREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    task automatic test_starvation;
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200; ramload = 32'hA5A50000;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++; if (ramaddr !== 32'h200 || ramREN !== 1'b1 || dut.starve !== 4'(g + 1)) begin errors++; $display("FAIL starve_dgrant%0d: addr %h ren %b starve %0d want 200 1 %0d", g, ramaddr, ramREN, dut.starve, g + 1); end
            ramstate = ACCESS;
            #1;
            checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL starve_dhit%0d: dwait %b iwait %b want 0 1", g, dwait, iwait); end
            tick();
            ramstate = FREE;
        end
        tick();
        checks++; if (ramaddr !== 32'h300 || ramREN !== 1'b1 || dut.starve !== 4'd0) begin errors++; $display("FAIL starve_igrant: addr %h ren %b starve %0d want 300 1 0", ramaddr, ramREN, dut.starve); end
        ramstate = ACCESS;
        #1;
        checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL starve_ihit: iwait %b dwait %b want 0 1", iwait, dwait); end
        tick();
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    task automatic test_write_both;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        tick();
        ramstate = BUSY;
        #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL write_enables: wen %b ren %b want 1 0", ramWEN, ramREN); end
        checks++; if (ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin errors++; $display("FAIL write_bus: store %h addr %h want deadbeef 100", ramstore, ramaddr); end
        checks++; if (dwait !== 1'b1 || dload !== 32'h0) begin errors++; $display("FAIL write_busy_wait: dwait %b dload %h want 1 0", dwait, dload); end
        tick();
        ramstate = ACCESS; ramload = 32'h0;
        #1;
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL write_hit: dwait %b want 0", dwait); end
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin errors++; $display("FAIL write_bubble: wen %b store %h want 0 0", ramWEN, ramstore); end
        tick();
    endtask

    task automatic test_withdraw;
        iREN = 1'b1; iaddr = 32'h500;
        tick();
        ramstate = BUSY;
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin errors++; $display("FAIL withdraw_grant: ren %b addr %h want 1 500", ramREN, ramaddr); end
        iREN = 1'b0;
        tick();
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL withdraw_idle: ren %b iwait %b want 0 1", ramREN, iwait); end
        ramstate = FREE;
        tick();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL withdraw_no_regrant: ren %b want 0", ramREN); end
    endtask

    task automatic test_error_retry;
        dREN = 1'b1; daddr = 32'h180;
        tick();
        ramstate = ERROR;
        #1;
        checks++; if (dwait !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL err_first: dwait %b cnt %0d want 1 0", dwait, err_count); end
        tick();
        ramstate = FREE;
        #1;
        checks++; if (err_count !== 8'd1 || ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL err_bubble: cnt %0d ren %b dwait %b want 1 0 1", err_count, ramREN, dwait); end
        tick();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h180) begin errors++; $display("FAIL err_regrant: ren %b addr %h want 1 180", ramREN, ramaddr); end
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE0001) begin errors++; $display("FAIL err_retry_hit: dwait %b dload %h want 0 cafe0001", dwait, dload); end
        tick();
        ramstate = FREE;
        for (int i = 0; i < 300; i++) begin
            tick();
            ramstate = ERROR;
            tick();
            ramstate = FREE;
            if (i == 252) begin
                checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL err_count_254: got %0d want 254", err_count); end
            end
        end
        dREN = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d want 255", err_count); end
        tick();
    endtask

    task automatic test_reset_mid_access;
        iREN = 1'b1; iaddr = 32'h600; dREN = 1'b1; daddr = 32'h700;
        tick();
        ramstate = BUSY;
        #1;
        checks++; if (ramREN !== 1'b1 || dut.starve !== 4'd1 || err_count !== 8'd255) begin errors++; $display("FAIL rstmid_pre: ren %b starve %0d cnt %0d want 1 1 255", ramREN, dut.starve, err_count); end
        RST = 1'b1; ramstate = ACCESS;
        #1;
        checks++; if (dwait !== 1'b1 || dload !== 32'h0) begin errors++; $display("FAIL rstmid_no_hit: dwait %b dload %h want 1 0", dwait, dload); end
        tick();
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rstmid_idle: dwait %b ren %b wen %b addr %h want 1 0 0 0", dwait, ramREN, ramWEN, ramaddr); end
        checks++; if (dut.starve !== 4'd0 || err_count !== 8'd0) begin errors++; $display("FAIL rstmid_counters: starve %0d cnt %0d want 0 0", dut.starve, err_count); end
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_priority();
        test_starvation();
        test_write_both();
        test_withdraw();
        test_error_retry();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
